// File: rtl/dmem_store_responder.sv
// -----------------------------------------------------------------------------
// dmem_store_responder
//
// Data-memory responder for the RV64 core's store port. Stores are queued in a
// DEPTH-entry FIFO and drained into a 64-bit word array. Each drain takes
// WR_LAT cycles in WRITE plus one COMMIT cycle. 64-bit reads get a one-cycle
// registered response and stay coherent with stores that are still buffered.
//
// Build option (macro DMEM_FWD_EN):
//   defined   : reads are always accepted. The youngest buffered store to the
//               same word is forwarded.
//   undefined : a read to a word with a buffered store is held off
//               (rd_ready=0) until that store has committed.
//
// Ports:
//   clk       in   1               rising-edge clock
//   rst_n     in   1               asynchronous active-low reset
//   memwrite  in   1               store request this cycle
//   address   in   64              store byte address
//   data      in   64              store data (full doubleword)
//   stall     out  1               store not accepted (buffer full)
//   rd_en     in   1               read request
//   rd_addr   in   64              read byte address
//   rd_ready  out  1               read accepted this cycle
//   rd_valid  out  1               rd_data valid (cycle after accept)
//   rd_data   out  64              read result
//   pending   out  $clog2(DEPTH)+1 buffered stores not yet committed
//   err       out  1               sticky: misaligned/out-of-range access seen
// -----------------------------------------------------------------------------
module dmem_store_responder #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
   parameter int unsigned WR_LAT    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     memwrite,
   input  logic [63:0]              address,
   input  logic [63:0]              data,
   output logic                     stall,
   input  logic                     rd_en,
   input  logic [63:0]              rd_addr,
   output logic                     rd_ready,
   output logic                     rd_valid,
   output logic [63:0]              rd_data,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned IDX_W = $clog2(MEM_WORDS);
   localparam int unsigned LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(WR_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WRITE  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   // An address is usable when it is doubleword aligned and inside the window.
   function automatic logic addr_ok(input logic [63:0] a);
      return (a[2:0] == 3'b000) && (a >= BASE_ADDR) &&
             ((a - BASE_ADDR) < (64'(MEM_WORDS) * 64'd8));
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [63:0] a);
      return IDX_W'((a - BASE_ADDR) >> 3);
   endfunction

   // Storage
   logic [63:0]      mem_q     [MEM_WORDS];
   logic [IDX_W-1:0] ent_idx_q [DEPTH];
   logic [63:0]      ent_dat_q [DEPTH];

   // Buffer bookkeeping
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   state_t           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;

   // Read / status registers
   logic             rd_valid_q;
   logic [63:0]      rd_data_q;
   logic             err_q;

   // Combinational helpers
   logic             full_s, st_ok_s, push_s, pop_s;
   logic [IDX_W-1:0] st_idx_s, rd_idx_s;
   logic             rd_ok_s, hit_s, rd_accept_s;
   logic [63:0]      fwd_data_s, rd_word_s;

   assign full_s   = (count_q == CNT_W'(DEPTH));
   assign st_ok_s  = addr_ok(address);
   assign st_idx_s = addr_idx(address);
   assign rd_ok_s  = addr_ok(rd_addr);
   assign rd_idx_s = addr_idx(rd_addr);

   // A full buffer refuses the store even if a commit frees a slot this edge.
   assign push_s = memwrite & ~full_s & st_ok_s;
   assign stall  = memwrite & full_s;

   // Next-state for the FIFO pointers and occupancy.
   always_comb begin
      head_d = pop_s  ? head_q + PTR_W'(1) : head_q;
      tail_d = push_s ? tail_q + PTR_W'(1) : tail_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Drain FSM: next state and latency counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != CNT_W'(0)) begin
               state_d = S_WRITE;
               cnt_d   = LAT_RELOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (cnt_q == LAT_W'(0)) begin
               state_d = S_COMMIT;
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         S_COMMIT: begin
            // count_d already accounts for this pop and any same-edge push.
            if (count_d != CNT_W'(0)) begin
               state_d = S_WRITE;
               cnt_d   = LAT_RELOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = LAT_W'(0);
         end
      endcase
   end

   // Drain FSM outputs: the head entry leaves the buffer on its COMMIT edge.
   always_comb begin
      pop_s = (state_q == S_COMMIT);
   end

   // Drain FSM state and FIFO control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= LAT_W'(0);
         head_q  <= PTR_W'(0);
         tail_q  <= PTR_W'(0);
         count_q <= CNT_W'(0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Buffer payload; validity comes from the count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         ent_idx_q[tail_q] <= st_idx_s;
         ent_dat_q[tail_q] <= data;
      end
   end

   // Backing array; the FSM is held in IDLE during reset, so no write then.
   always_ff @(posedge clk) begin
      if (pop_s) begin
         mem_q[ent_idx_q[head_q]] <= ent_dat_q[head_q];
      end
   end

   // Scan buffered entries oldest to youngest; the last match wins.
   always_comb begin
      logic [PTR_W-1:0] pos_v;
      logic             m_v;
      hit_s      = 1'b0;
      fwd_data_s = 64'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         pos_v      = head_q + PTR_W'(i);
         m_v        = rd_ok_s && (CNT_W'(i) < count_q) && (ent_idx_q[pos_v] == rd_idx_s);
         hit_s      = hit_s | m_v;
         fwd_data_s = m_v ? ent_dat_q[pos_v] : fwd_data_s;
      end
   end

`ifdef DMEM_FWD_EN
   assign rd_ready = 1'b1;
`else
   assign rd_ready = ~hit_s;
`endif

   assign rd_accept_s = rd_en & rd_ready;

   // Read result. Without forwarding, hit_s is never set on an accepted read.
   always_comb begin
      if (!rd_ok_s) begin
         rd_word_s = 64'd0;
      end else if (hit_s) begin
         rd_word_s = fwd_data_s;
      end else begin
         rd_word_s = mem_q[rd_idx_s];
      end
   end

   // Registered read response and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= 64'd0;
         err_q      <= 1'b0;
      end else begin
         err_q <= err_q | (memwrite & ~st_ok_s) | (rd_accept_s & ~rd_ok_s);
         if (rd_accept_s) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_word_s;
         end else begin
            rd_valid_q <= 1'b0;
         end
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign pending  = count_q;
   assign err      = err_q;

endmodule

// File: tb/tb_dmem_store_responder.sv
// Self-checking bench for dmem_store_responder (default parameters).
// Expected read data comes from a reference word model. It is queued when a
// read is accepted and compared when rd_valid appears.
module tb_dmem_store_responder;

   localparam int unsigned DEPTH     = 4;
   localparam int unsigned MEM_WORDS = 1024;
   localparam int unsigned WR_LAT    = 2;
   localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        memwrite = 1'b0;
   logic [63:0] address = 64'd0;
   logic [63:0] data = 64'd0;
   logic        rd_en = 1'b0;
   logic [63:0] rd_addr = 64'd0;
   logic        stall, rd_ready, rd_valid, err;
   logic [63:0] rd_data;
   logic [2:0]  pending;

   int checks_n = 0;
   int errors_n = 0;
   logic [63:0] exp_q [$];
   logic [63:0] ref_mem [int];

   always #5 clk = ~clk;

   dmem_store_responder #(
      .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .WR_LAT(WR_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .address(address), .data(data),
      .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .pending(pending), .err(err)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_n++;
      if (got !== exp) begin
         errors_n++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int widx(input logic [63:0] a);
      return int'((a - BASE) >> 3);
   endfunction

   // Read-response monitor: every rd_valid consumes one expected value.
   always @(negedge clk) begin
      if (rst_n && rd_valid === 1'b1) begin
         check_val("rd_outstanding", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) check_val("rd_data", rd_data, exp_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a valid store; hold it while stalled. Returns the stall cycle count.
   task automatic do_store(input logic [63:0] a, input logic [63:0] d, output int stalls);
      stalls = 0;
      memwrite = 1'b1; address = a; data = d;
      @(negedge clk);
      while (stall === 1'b1 && stalls < 50) begin
         stalls++;
         @(negedge clk);
      end
      check_val("st_accept_tmo", 64'(stall), 64'd0);
      @(posedge clk); #1;
      memwrite = 1'b0;
      ref_mem[widx(a)] = d;
   endtask

   // Issue a read, wait (bounded) for rd_ready, queue the expected value.
   task automatic do_read(input logic [63:0] a, input logic [63:0] exp,
                          output int waits, output logic [2:0] pend_acc);
      waits = 0;
      rd_en = 1'b1; rd_addr = a;
      @(negedge clk);
      while (rd_ready !== 1'b1 && waits < 100) begin
         waits++;
         @(negedge clk);
      end
      check_val("rd_accept_tmo", 64'(rd_ready), 64'd1);
      pend_acc = pending;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (pending != 3'd0 && n < 100) begin
         n++;
         step();
      end
      check_val("drain_tmo", 64'(pending), 64'd0);
   endtask

   initial begin
      int          s, w, n;
      logic [2:0]  pa;
      logic [63:0] a;

      // Reset values
      #12;
      check_val("rst_pending", 64'(pending), 64'd0);
      check_val("rst_stall", 64'(stall), 64'd0);
      check_val("rst_rd_valid", 64'(rd_valid), 64'd0);
      check_val("rst_rd_data", rd_data, 64'd0);
      check_val("rst_err", 64'(err), 64'd0);
      check_val("rst_rd_ready", 64'(rd_ready), 64'd1);
      rst_n = 1'b1;
      step();

      // Known contents for words used later
      do_store(BASE, 64'd0, s);
      do_store(BASE + 64'h18, 64'h5, s);
      wait_idle();

      // Single store: pending stays 1 through IDLE, WR_LAT WRITE cycles and COMMIT
      memwrite = 1'b1; address = BASE + 64'h8; data = 64'hDEAD;
      step();
      memwrite = 1'b0;
      ref_mem[1] = 64'hDEAD;
      check_val("t2_pend_after_push", 64'(pending), 64'd1);
      n = 0;
      while (pending != 3'd0 && n < 100) begin
         n++;
         step();
      end
      check_val("t2_pend_cycles", 64'(n), 64'(WR_LAT + 2));
      do_read(BASE + 64'h8, ref_mem[1], w, pa);

      // Five back-to-back stores: only the fifth waits, for one cycle
      for (int k = 0; k < 5; k++) begin
         do_store(BASE + 64'h20 + 64'(8 * k), 64'h100 + 64'(k), s);
         check_val($sformatf("t3_stall%0d", k), 64'(s), (k == 4) ? 64'd1 : 64'd0);
      end
      wait_idle();
      for (int k = 0; k < 5; k++) begin
         a = BASE + 64'h20 + 64'(8 * k);
         do_read(a, ref_mem[widx(a)], w, pa);
      end

      // Two stores to one word, then an immediate read
      do_store(BASE + 64'h10, 64'h11, s);
      do_store(BASE + 64'h10, 64'h22, s);
      do_read(BASE + 64'h10, 64'h22, w, pa);
`ifdef DMEM_FWD_EN
      check_val("t4_fwd_waits", 64'(w), 64'd0);
`else
      check_val("t4_blocked", 64'(w > 0), 64'd1);
      check_val("t4_pend_at_accept", 64'(pa), 64'd0);
`endif
      wait_idle();

      // Last word of the window is a legal store
      a = BASE + 64'(8 * (MEM_WORDS - 1));
      do_store(a, 64'hABCD, s);
      wait_idle();
      do_read(a, ref_mem[widx(a)], w, pa);
      check_val("t5_err_clear", 64'(err), 64'd0);

      // One past the window, misaligned store, out-of-range read
      memwrite = 1'b1; address = BASE + 64'(8 * MEM_WORDS); data = 64'h77;
      @(negedge clk);
      check_val("t5_no_stall", 64'(stall), 64'd0);
      step();
      memwrite = 1'b0;
      check_val("t5_oor_pend", 64'(pending), 64'd0);
      check_val("t5_oor_err", 64'(err), 64'd1);
      memwrite = 1'b1; address = BASE + 64'h4; data = 64'h99;
      step();
      memwrite = 1'b0;
      check_val("t5_mis_pend", 64'(pending), 64'd0);
      do_read(64'h0000_0000_7000_0000, 64'd0, w, pa);
      step(); step();
      check_val("t5_err_sticky", 64'(err), 64'd1);

      // Same-cycle store and read: the read sees the old word
      memwrite = 1'b1; address = BASE + 64'h18; data = 64'h66;
      rd_en = 1'b1; rd_addr = BASE + 64'h18;
      @(negedge clk);
      check_val("t6_stall", 64'(stall), 64'd0);
      check_val("t6_ready", 64'(rd_ready), 64'd1);
      exp_q.push_back(ref_mem[3]);
      step();
      memwrite = 1'b0; rd_en = 1'b0;
      ref_mem[3] = 64'h66;
      do_read(BASE + 64'h18, ref_mem[3], w, pa);
      wait_idle();

      // Reset in the middle of a drain discards the in-flight store
      do_store(BASE, 64'hBAD, s);
      ref_mem[0] = 64'd0;
      step(); step();
      rst_n = 1'b0;
      #1;
      check_val("t1_pending", 64'(pending), 64'd0);
      check_val("t1_rd_data", rd_data, 64'd0);
      check_val("t1_rd_valid", 64'(rd_valid), 64'd0);
      check_val("t1_err", 64'(err), 64'd0);
      check_val("t1_stall", 64'(stall), 64'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      do_read(BASE, ref_mem[0], w, pa);
      step(); step();

      check_val("rd_leftover", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
      $finish;
   end

endmodule
